swi_debounce_led: RTL and testbench

- Parametrised successor to the board's purely combinational switch-to-LED logic.
- Synchronises and debounces NCH raw slide-switch inputs and produces one-cycle rise/fall pulses.
- Drives a registered LED per channel in one of four selectable modes.
- Sits between the board SWI pins and LED/SEG consumers inside top; the clock is clk_2.

---
 rtl/swi_pkg.sv | 13 +
 rtl/swi_debounce_ch.sv | 63 ++++++
 rtl/swi_debounce_led.sv | 75 +++++++
 tb/tb_swi_debounce_led.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/swi_pkg.sv
// Shared types and defaults for the switch debounce / LED driver slice.
package swi_pkg;

   typedef enum logic [1:0] {
      DIRECT = 2'd0,
      TOGGLE = 2'd1,
      LATCH  = 2'd2,
      INVERT = 2'd3
   } led_mode_t;

   localparam int DEB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/swi_debounce_ch.sv
// One switch channel: 2-flop synchroniser, disagreement-run debounce counter,
// debounced level and registered one-cycle rise/fall pulses.
module swi_debounce_ch
   import swi_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          rise_q, fall_q;
   logic          accept_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter holds the length of the current run of disagreement; it
   // resets on agreement and on acceptance, so only a clean run is accepted.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      accept_d = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (int'(cnt_q) + 1 >= DEB_CYCLES) begin
         cnt_d    = '0;
         stable_d = sync2_q;
         accept_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= accept_d & sync2_q;
         fall_q   <= accept_d & ~sync2_q;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;

endmodule

// File: rtl/swi_debounce_led.sv
// NCH-channel switch debouncer with registered LED modes and optional
// saturating per-channel rise counters (enabled by SWI_EVT_CNT_EN).
module swi_debounce_led
   import swi_pkg::*;
#(
   parameter int NCH        = 8,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = 8
) (
   input  logic                 clk_2,
   input  logic                 reset_n,
   input  logic [NCH-1:0]       swi_raw,
   input  logic [1:0]           mode,
   input  logic                 clr,
   output logic [NCH-1:0]       swi_stable,
   output logic [NCH-1:0]       rise,
   output logic [NCH-1:0]       fall,
   output logic [NCH-1:0]       led,
   output logic [NCH*CNT_W-1:0] evt_cnt
);

   led_mode_t      mode_s;
   logic [NCH-1:0] led_q, led_d;

   assign mode_s = led_mode_t'(mode);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      swi_debounce_ch #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_ch (
         .clk_i   (clk_2),
         .rst_ni  (reset_n),
         .raw_i   (swi_raw[i]),
         .stable_o(swi_stable[i]),
         .rise_o  (rise[i]),
         .fall_o  (fall[i])
      );
   end

   // TOGGLE/LATCH continue from whatever led_q holds when the mode switches.
   always_comb begin
      led_d = led_q;
      case (mode_s)
         DIRECT:  led_d = swi_stable;
         INVERT:  led_d = ~swi_stable;
         TOGGLE:  led_d = clr ? '0 : (led_q ^ rise);
         LATCH:   led_d = clr ? '0 : (led_q | rise);
         default: led_d = led_q;
      endcase
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) led_q <= '0;
      else          led_q <= led_d;
   end

   assign led = led_q;

`ifdef SWI_EVT_CNT_EN
   for (genvar i = 0; i < NCH; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk_2 or negedge reset_n) begin
         if (!reset_n)                  cnt_q <= '0;
         else if (clr)                  cnt_q <= '0;
         else if (rise[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end

      assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
   end
`else
   assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_swi_debounce_led.sv
// Directed bench for swi_debounce_led with a sliding-window reference model.
module tb_swi_debounce_led;

   localparam int NCH   = 8;
   localparam int DEB   = 4;
   localparam int CNT_W = 2;

   logic                 clk_2   = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NCH-1:0]       swi_raw = '1;
   logic [1:0]           mode    = 2'd0;
   logic                 clr     = 1'b0;
   logic [NCH-1:0]       swi_stable, rise, fall, led;
   logic [NCH*CNT_W-1:0] evt_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   bit started = 1'b0;
   int fall2 = 0;
   int exp_cnt [5];

   swi_debounce_led #(.NCH(NCH), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .swi_raw   (swi_raw),
      .mode      (mode),
      .clr       (clr),
      .swi_stable(swi_stable),
      .rise      (rise),
      .fall      (fall),
      .led       (led),
      .evt_cnt   (evt_cnt)
   );

   always #5 clk_2 = ~clk_2;

   // Reference: a level is accepted when the raw samples that reached the
   // second synchroniser stage over the last DEB edges all oppose it.
   logic [NCH-1:0]            hist [0:DEB];
   logic [NCH-1:0]            m_stable = '0, m_rise = '0, m_fall = '0, m_led = '0;
   logic [NCH-1:0][CNT_W-1:0] m_cnt = '0;

   initial for (int k = 0; k <= DEB; k++) hist[k] = '0;

   always @(posedge clk_2 or negedge reset_n) begin
      logic [NCH-1:0] ns;
      bit opp;
      if (!reset_n) begin
         m_stable <= '0; m_rise <= '0; m_fall <= '0; m_led <= '0; m_cnt <= '0;
         for (int k = 0; k <= DEB; k++) hist[k] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            opp = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (hist[k][c] == m_stable[c]) opp = 1'b0;
            ns[c] = opp ? ~m_stable[c] : m_stable[c];
`ifdef SWI_EVT_CNT_EN
            if (clr) m_cnt[c] <= '0;
            else if (m_rise[c] && int'(m_cnt[c]) < (1 << CNT_W) - 1) m_cnt[c] <= m_cnt[c] + 1'b1;
`endif
         end
         m_rise   <= ns & ~m_stable;
         m_fall   <= ~ns & m_stable;
         m_stable <= ns;
         case (mode)
            2'd0: m_led <= m_stable;
            2'd3: m_led <= ~m_stable;
            2'd1: m_led <= clr ? '0 : (m_led ^ m_rise);
            default: m_led <= clr ? '0 : (m_led | m_rise);
         endcase
         for (int k = DEB; k >= 1; k--) hist[k] <= hist[k-1];
         hist[0] <= swi_raw;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk_2) begin
      if (started) begin
         chk("mdl_stable", 32'(swi_stable), 32'(m_stable));
         chk("mdl_rise",   32'(rise),       32'(m_rise));
         chk("mdl_fall",   32'(fall),       32'(m_fall));
         chk("mdl_led",    32'(led),        32'(m_led));
         chk("mdl_cnt",    32'(evt_cnt),    32'(m_cnt));
         chk("rise_fall_excl", 32'(rise & fall), 32'd0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_2);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         step(1);
         if (fall[2]) fall2++;
      end
   endtask

   initial begin
`ifdef SWI_EVT_CNT_EN
      exp_cnt = '{1, 2, 3, 3, 3};
`else
      exp_cnt = '{0, 0, 0, 0, 0};
`endif
      // 1: reset and release with all switches high
      step(3);
      started = 1'b1;
      chk("rst_stable", 32'(swi_stable), 32'd0);
      chk("rst_rise",   32'(rise),       32'd0);
      chk("rst_led",    32'(led),        32'd0);
      chk("rst_cnt",    32'(evt_cnt),    32'd0);
      reset_n = 1'b1;
      step(5);
      chk("t1_edge5_stable", 32'(swi_stable), 32'h00);
      step(1);
      chk("t1_edge6_stable", 32'(swi_stable), 32'hFF);
      chk("t1_edge6_rise",   32'(rise),       32'hFF);
      step(1);
      chk("t1_edge7_rise", 32'(rise), 32'h00);
      chk("t1_edge7_led",  32'(led),  32'hFF);

      // 2: glitch rejection then a minimum-length press
      swi_raw = '0;
      step(12);
      chk("t2_idle_stable", 32'(swi_stable), 32'h00);
      swi_raw[0] = 1'b1;
      step(3);
      swi_raw[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("t2_glitch", 32'({swi_stable[0], rise[0], led[0]}), 32'd0);
      end
      swi_raw[0] = 1'b1;
      step(4);
      swi_raw[0] = 1'b0;
      step(1);
      chk("t2_edge5", 32'(swi_stable[0]), 32'd0);
      step(1);
      chk("t2_edge6", 32'(swi_stable[0]), 32'd1);
      step(12);

      // 3: TOGGLE on channel 2
      mode = 2'd1;
      step(1);
      fall2 = 0;
      swi_raw[2] = 1'b1; run(10);
      chk("t3_led_on", 32'(led), 32'h04);
      swi_raw[2] = 1'b0; run(10);
      chk("t3_led_hold", 32'(led), 32'h04);
      swi_raw[2] = 1'b1; run(10);
      chk("t3_led_off", 32'(led), 32'h00);
      swi_raw[2] = 1'b0; run(10);
      chk("t3_fall_pulses", 32'(fall2), 32'd2);

      // 4: LATCH, then clr coincident with a rise
      mode = 2'd2;
      swi_raw[5] = 1'b1; step(10);
      chk("t4_latch", 32'(led), 32'h20);
      swi_raw[5] = 1'b0; step(10);
      chk("t4_hold", 32'(led), 32'h20);
      swi_raw[5] = 1'b1;
      step(6);
      chk("t4_rise5", 32'(rise), 32'h20);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("t4_clr_led", 32'(led), 32'h00);
      chk("t4_clr_cnt", 32'(evt_cnt[5*CNT_W +: CNT_W]), 32'd0);
      swi_raw[5] = 1'b0; step(10);

      // 5: counter saturation on channel 1
      mode = 2'd0;
      clr = 1'b1; step(1); clr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         swi_raw[1] = 1'b1; step(10);
         chk("t5_cnt1", 32'(evt_cnt[1*CNT_W +: CNT_W]), 32'(exp_cnt[k]));
         swi_raw[1] = 1'b0; step(10);
      end

      // 6: reset in the middle of a debounce window
      swi_raw[3] = 1'b1;
      step(4);
      reset_n = 1'b0;
      step(2);
      chk("t6_in_reset", 32'(swi_stable), 32'd0);
      reset_n = 1'b1;
      step(5);
      chk("t6_edge5", 32'(swi_stable[3]), 32'd0);
      step(1);
      chk("t6_edge6", 32'(swi_stable[3]), 32'd1);
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
